mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-ported RAM between two requesters: the instruction-fetch port (I, read-only) and the load/store data port (D, read/write).
- Registers each accepted request, sequences the RAM's rdEn/wrEn/addr and its shared tristate data bus, captures read data, and returns a one-cycle completion pulse.
- Sits between the CPU core and the RAM; it is the only driver of the RAM control pins.

Parameters:
- DWIDTH, 32, data width; must match the RAM.
- AWIDTH, 10, address width; must match the RAM.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset.
- i_req  in  1  fetch request.
- i_addr  in  AWIDTH  fetch address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rdata  out  DWIDTH  fetched word.
- i_rvalid  out  1  one-cycle pulse; i_rdata valid.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AWIDTH  data address.
- d_wdata  in  DWIDTH  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rdata  out  DWIDTH  load result.
- d_done  out  1  one-cycle pulse; read data valid or write committed.
- mem_addr  out  AWIDTH  to RAM addr.
- mem_rdEn  out  1  to RAM rdEn.
- mem_wrEn  out  1  to RAM wrEn.
- mem_data  inout  DWIDTH  RAM shared data bus.
- busy  out  1  high while in ARB_ACCESS.

Behaviour:
- States:
  - ARB_IDLE: no access in progress.
  - ARB_ACCESS: RAM is being driven for the latched request.
  - ARB_RESP: completion cycle.
- Arbitration runs in ARB_IDLE and ARB_RESP.
  - i_gnt and d_gnt are combinational; at most one is high.
  - At the posedge where a gnt is high, the arbiter latches owner, address, we and wdata, and moves to ARB_ACCESS.
  - Otherwise the next state is ARB_IDLE.
- Fixed priority (default): D beats I. i_gnt = i_req & ~d_req.
- ARB_ACCESS (exactly one cycle):
  - mem_addr = latched address.
  - Read: mem_rdEn = 1, mem_wrEn = 0. At the closing posedge the arbiter captures mem_data into the owner's rdata register.
  - Write: mem_wrEn = 1, mem_rdEn = 0, mem_data driven with latched wdata. The RAM commits on the negedge inside this cycle.
  - Next state: ARB_RESP.
- ARB_RESP:
  - i_rvalid (I read) or d_done (D read/write) is high for exactly this cycle.
  - A new grant is allowed in the same cycle, giving back-to-back throughput of 1 access per 2 cycles and latency of 2 cycles from grant to completion pulse.
- Bus rules:
  - mem_data is 'z except in ARB_ACCESS with a latched write.
  - mem_rdEn and mem_wrEn are never high together.
  - Outside ARB_ACCESS: mem_rdEn = mem_wrEn = 0 and mem_addr = 0.
- i_rdata and d_rdata hold their value until the next read completion for that port.
- A requester must hold req/addr/we/wdata stable until gnt. Dropping req before gnt withdraws the request with no effect.
- d_req with d_we = 1 toward I-port addresses has no special handling; coherency belongs to the core.
- Addresses are passed through unchecked; addr ≥ MEMDEPTH is the RAM's concern.
- Reset (reset == 0 at posedge):
  - state → ARB_IDLE.
  - All outputs 0; mem_data 'z; rdata registers 0.
  - The round-robin pointer (if compiled in) → D.
- Reset during ARB_ACCESS:
  - The access is aborted and no completion pulse is produced.
  - A write may already have been committed at the preceding negedge; this is accepted.
- Gnt outputs are forced to 0 while reset is low.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_owner register is updated on every grant. When i_req and d_req are both high, the port that was NOT last granted wins. Single requesters are granted as normal.
- Undefined: fixed D-over-I priority; no last_owner register.

Decomposition:
- Package InstructionStruct holds:
  - DWIDTH, AWIDTH, MEMDEPTH (shared with the RAM).
  - arb_state_t enum {ARB_IDLE, ARB_ACCESS, ARB_RESP}.
  - arb_owner_t enum {OWN_I, OWN_D}.
- One sub-module, mem_arb_pick: combinational selector taking i_req, d_req, last_owner and en, returning i_gnt, d_gnt. It contains the ARB_ROUND_ROBIN_EN logic.

Test Plan:
- I read: preload mem[5] = 0xDEADBEEF; i_req = 1, i_addr = 5 in cycle 0 → i_gnt = 1 in cycle 0, mem_rdEn = 1 / mem_addr = 5 in cycle 1, i_rvalid = 1 and i_rdata = 0xDEADBEEF in cycle 2.
- D write then read: d_we = 1, d_addr = 7, d_wdata = 0x1234 → mem_wrEn = 1 with bus driven for 1 cycle, d_done at +2. Then read addr 7 → d_rdata = 0x1234; bus 'z at all other times.
- Contention: i_req and d_req both held high for 6 cycles → fixed priority grants D three times back-to-back and I never. With ARB_ROUND_ROBIN_EN, grants alternate D, I, D.
- Back-to-back: I read grant issued in the ARB_RESP cycle of a prior D write → completion pulses exactly 2 cycles apart; rdEn and wrEn are never both 1.
- Reset mid-access: reset = 0 during ARB_ACCESS of a read → next cycle all outputs 0, state IDLE, no i_rvalid. After release, a new request completes normally.
- Withdraw: i_req high for one cycle while d_req holds the arbiter, then i_req drops → no i_gnt, no i_rvalid.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM arbiter.
// Holds the RAM geometry (shared with the RAM model) plus the arbiter FSM
// state and owner encodings.
package InstructionStruct;

  localparam int unsigned DWIDTH   = 32;
  localparam int unsigned AWIDTH   = 10;
  localparam int unsigned MEMDEPTH = 1 << AWIDTH;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector for the RAM arbiter.
// Optional macro: ARB_ROUND_ROBIN_EN -- when defined, contention is resolved
// in favour of the port that was not granted last; otherwise D beats I.
// Ports:
//   i_req_i, d_req_i  : requests from fetch (I) and load/store (D) ports
//   last_owner_i      : port granted most recently (round-robin only)
//   en_i              : arbitration allowed this cycle
//   i_gnt_o, d_gnt_o  : one-hot (or zero) grant
module mem_arb_pick
  import InstructionStruct::*;
(
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  arb_owner_t last_owner_i,
  input  logic       en_i,
  output logic       i_gnt_o,
  output logic       d_gnt_o
);

  logic d_wins;

`ifdef ARB_ROUND_ROBIN_EN
  // Under contention D only wins if I was the port served last.
  assign d_wins = d_req_i & (~i_req_i | (last_owner_i == OWN_I));
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;
  assign d_wins = d_req_i;
`endif

  assign d_gnt_o = en_i & d_wins;
  assign i_gnt_o = en_i & i_req_i & ~d_wins;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported RAM between the instruction-fetch port
// (I, read-only) and the load/store port (D, read/write).
// Each accepted request takes one ARB_ACCESS cycle on the RAM and produces a
// one-cycle completion pulse in the following ARB_RESP cycle, in which a new
// grant may already be issued (one access per two cycles).
// Optional macro: ARB_ROUND_ROBIN_EN (alternate grants under contention).
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   i_req/i_addr/i_gnt         : fetch request handshake
//   i_rdata/i_rvalid           : fetched word and its completion pulse
//   d_req/d_we/d_addr/d_wdata  : data request
//   d_gnt/d_rdata/d_done       : data grant, load result, completion pulse
//   mem_addr/mem_rdEn/mem_wrEn : RAM control, idle-low
//   mem_data                   : RAM shared tristate data bus
//   busy                       : high while the RAM is being accessed
module mem_arbiter #(
  parameter int unsigned DWIDTH = InstructionStruct::DWIDTH,
  parameter int unsigned AWIDTH = InstructionStruct::AWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  output logic              i_gnt,
  output logic [DWIDTH-1:0] i_rdata,
  output logic              i_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              d_done,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rdEn,
  output logic              mem_wrEn,
  inout  wire  [DWIDTH-1:0] mem_data,
  output logic              busy
);

  import InstructionStruct::*;

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q;
  arb_owner_t        last_owner;
  logic              we_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] i_rdata_q;
  logic [DWIDTH-1:0] d_rdata_q;
  logic              arb_en;
  logic              any_gnt;
  logic              in_access;

  assign in_access = (state_q == ARB_ACCESS);
  // Grants are held off during reset and while the RAM is occupied.
  assign arb_en    = reset & ~in_access;
  assign any_gnt   = i_gnt | d_gnt;

  mem_arb_pick u_pick (
    .i_req_i      (i_req),
    .d_req_i      (d_req),
    .last_owner_i (last_owner),
    .en_i         (arb_en),
    .i_gnt_o      (i_gnt),
    .d_gnt_o      (d_gnt)
  );

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_owner_q;

  // Starts as if I was served last, so the first contention goes to D.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_owner_q <= OWN_I;
    end else if (d_gnt) begin
      last_owner_q <= OWN_D;
    end else if (i_gnt) begin
      last_owner_q <= OWN_I;
    end
  end

  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_D;
`endif

  always_comb begin
    state_d = ARB_IDLE;
    unique case (state_q)
      ARB_ACCESS: state_d = ARB_RESP;
      default:    state_d = any_gnt ? ARB_ACCESS : ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (any_gnt) begin
        owner_q <= d_gnt ? OWN_D : OWN_I;
        we_q    <= d_gnt & d_we;
        addr_q  <= d_gnt ? d_addr : i_addr;
        wdata_q <= d_wdata;
      end
      // The RAM presents read data during the access cycle.
      if (in_access && !we_q) begin
        if (owner_q == OWN_D) begin
          d_rdata_q <= mem_data;
        end else begin
          i_rdata_q <= mem_data;
        end
      end
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_rdEn = 1'b0;
    mem_wrEn = 1'b0;
    if (in_access) begin
      mem_addr = addr_q;
      mem_rdEn = ~we_q;
      mem_wrEn = we_q;
    end
  end

  assign mem_data = (in_access && we_q) ? wdata_q : {DWIDTH{1'bz}};

  assign busy     = in_access;
  assign i_rvalid = (state_q == ARB_RESP) && (owner_q == OWN_I);
  assign d_done   = (state_q == ARB_RESP) && (owner_q == OWN_D);
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule
